// File: rtl/vc_arb_crossbar.sv
// vc_arb_crossbar: NxN crossbar with per-output round-robin arbitration into one-entry output registers.
// Destinations >= NPORTS are accepted and dropped, flagged by a one-cycle err_drop pulse.
module vc_arb_crossbar #(
  parameter int NPORTS    = 4,
  parameter int BIT_WIDTH = 32,
  parameter int SEL_W     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NPORTS-1:0]           in_val,
  output logic [NPORTS-1:0]           in_rdy,
  input  logic [NPORTS*BIT_WIDTH-1:0] in_msg,
  input  logic [NPORTS*SEL_W-1:0]     in_dest,
  output logic [NPORTS-1:0]           out_val,
  input  logic [NPORTS-1:0]           out_rdy,
  output logic [NPORTS*BIT_WIDTH-1:0] out_msg,
  output logic                        err_drop
);
  logic [NPORTS-1:0]    val_q, val_d, free, bad, hit;
  logic [BIT_WIDTH-1:0] msg_q [NPORTS];
  logic [BIT_WIDTH-1:0] msg_d [NPORTS];
  logic [SEL_W-1:0]     ptr_q [NPORTS];
  logic [SEL_W-1:0]     ptr_d [NPORTS];
  logic [NPORTS-1:0]    req [NPORTS];
  logic [NPORTS-1:0]    gnt [NPORTS];
  logic                 err_q;
  function automatic int wrap(input int a);
    return a % NPORTS;
  endfunction
  // Requests are gated by in_val so dest bits of idle inputs are never consumed
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      bad[i] = in_val[i] && ({1'b0, in_dest[i*SEL_W +: SEL_W]} >= (SEL_W+1)'(NPORTS));
      for (int j = 0; j < NPORTS; j++)
        req[j][i] = in_val[i] && (in_dest[i*SEL_W +: SEL_W] == SEL_W'(j));
    end
  end
  assign free = ~val_q | out_rdy;
  always_comb begin
    gnt   = '{default: '0};
    hit   = '0;
    val_d = val_q;
    msg_d = msg_q;
    ptr_d = ptr_q;
    for (int j = 0; j < NPORTS; j++) begin
      for (int k = 0; k < NPORTS; k++)
        if (free[j] && !hit[j] && req[j][wrap(int'(ptr_q[j]) + k)]) begin
          hit[j] = 1'b1;
          gnt[j][wrap(int'(ptr_q[j]) + k)] = 1'b1;
          ptr_d[j] = SEL_W'(wrap(int'(ptr_q[j]) + k + 1));
          msg_d[j] = in_msg[wrap(int'(ptr_q[j]) + k)*BIT_WIDTH +: BIT_WIDTH];
        end
      val_d[j] = hit[j] || (val_q[j] && !out_rdy[j]);
    end
  end
  always_comb begin
    in_rdy = '0;
    for (int i = 0; i < NPORTS; i++) begin
      for (int j = 0; j < NPORTS; j++)
        in_rdy[i] = in_rdy[i] | gnt[j][i];
      in_rdy[i] = !reset && (in_rdy[i] || bad[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      err_q <= 1'b0;
      for (int j = 0; j < NPORTS; j++) begin
        msg_q[j] <= '0;
        ptr_q[j] <= '0;
      end
    end else begin
      val_q <= val_d;
      msg_q <= msg_d;
      ptr_q <= ptr_d;
      err_q <= |bad;
    end
  end
  always_comb begin
    out_msg = '0;
    for (int j = 0; j < NPORTS; j++)
      out_msg[j*BIT_WIDTH +: BIT_WIDTH] = msg_q[j];
  end
  assign out_val  = val_q;
  assign err_drop = err_q;
endmodule

// File: tb/tb_vc_arb_crossbar.sv
// tb_vc_arb_crossbar: directed checks of routing, arbitration, backpressure, drops and reset.
module tb_vc_arb_crossbar;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_val, in_rdy, out_val, out_rdy;
  logic [127:0] in_msg, out_msg;
  logic [7:0]   in_dest;
  logic         err_drop;
  logic [2:0]   v3, r3, ov3, or3;
  logic [95:0]  m3, om3;
  logic [5:0]   d3;
  logic         e3;
  int checks = 0, errors = 0, n0 = 0, n3 = 0;

  vc_arb_crossbar #(.NPORTS(4), .BIT_WIDTH(32), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .in_dest(in_dest), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .err_drop(err_drop));

  vc_arb_crossbar #(.NPORTS(3), .BIT_WIDTH(32), .SEL_W(2)) u3 (
    .clk(clk), .reset(reset), .in_val(v3), .in_rdy(r3), .in_msg(m3),
    .in_dest(d3), .out_val(ov3), .out_rdy(or3), .out_msg(om3), .err_drop(e3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setp(input int i, input logic v, input logic [1:0] d, input logic [31:0] m);
    in_val[i]         = v;
    in_dest[i*2 +: 2] = d;
    in_msg[i*32 +: 32] = m;
  endtask

  function automatic logic [31:0] om(input int j);
    return out_msg[j*32 +: 32];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_val = '0; in_msg = '0; in_dest = '0; out_rdy = '0;
    v3 = '0; m3 = '0; d3 = '0; or3 = '0;
    step;
    in_val = 4'hf;
    #1 chk("rdy_in_reset", 64'(in_rdy), 64'h0);
    step;
    chk("rst_out_val", 64'(out_val), 64'h0);
    chk("rst_msg_lo", out_msg[63:0], 64'h0);
    chk("rst_msg_hi", out_msg[127:64], 64'h0);
    chk("rst_err", 64'(err_drop), 64'h0);
    chk("rst_u3_val", 64'(ov3), 64'h0);
    chk("rst_u3_err", 64'(e3), 64'h0);
    reset = 1'b0; in_val = '0;

    // identity routing
    for (int i = 0; i < 4; i++) setp(i, 1'b1, 2'(i), 32'hA0 + 32'(i));
    out_rdy = 4'hf;
    #1 chk("id_rdy", 64'(in_rdy), 64'hf);
    step;
    chk("id_val", 64'(out_val), 64'hf);
    for (int j = 0; j < 4; j++) chk("id_msg", 64'(om(j)), 64'hA0 + 64'(j));
    in_val = '0;
    step;
    chk("id_drain", 64'(out_val), 64'h0);

    // contention on out3: ptr[3] is 0 after identity grant from input 3
    setp(0, 1'b1, 2'd3, 32'h10); setp(1, 1'b1, 2'd3, 32'h11); setp(2, 1'b1, 2'd3, 32'h12);
    #1 chk("ct_rdy0", 64'(in_rdy), 64'h1);
    step;
    chk("ct_val0", 64'(out_val), 64'h8);
    chk("ct_msg0", 64'(om(3)), 64'h10);
    in_val[0] = 1'b0;
    #1 chk("ct_rdy1", 64'(in_rdy), 64'h2);
    step;
    chk("ct_msg1", 64'(om(3)), 64'h11);
    in_val[1] = 1'b0;
    #1 chk("ct_rdy2", 64'(in_rdy), 64'h4);
    step;
    chk("ct_msg2", 64'(om(3)), 64'h12);
    in_val[2] = 1'b0;
    step;
    chk("ct_drain", 64'(out_val), 64'h0);
    setp(0, 1'b1, 2'd3, 32'h30); setp(3, 1'b1, 2'd3, 32'h33);
    #1 chk("ct_ptr3", 64'(in_rdy), 64'h8);
    step;
    chk("ct_ptr3_msg", 64'(om(3)), 64'h33);
    in_val = '0;
    step;

    // backpressure on out1
    out_rdy = 4'b1101;
    setp(0, 1'b1, 2'd1, 32'hB0);
    #1 chk("bp_rdy0", 64'(in_rdy), 64'h1);
    step;
    chk("bp_val0", 64'(out_val), 64'h2);
    chk("bp_msg0", 64'(om(1)), 64'hB0);
    in_val[0] = 1'b0;
    setp(2, 1'b1, 2'd1, 32'hB2);
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_stall_rdy", 64'(in_rdy), 64'h0);
      step;
      chk("bp_hold_val", 64'(out_val), 64'h2);
      chk("bp_hold_msg", 64'(om(1)), 64'hB0);
    end
    out_rdy = 4'hf;
    #1 chk("bp_rel_rdy", 64'(in_rdy), 64'h4);
    step;
    chk("bp_val1", 64'(out_val), 64'h2);
    chk("bp_msg1", 64'(om(1)), 64'hB2);
    in_val = '0;
    step;
    chk("bp_drain", 64'(out_val), 64'h0);

    // reset mid-stream
    out_rdy = '0;
    setp(0, 1'b1, 2'd0, 32'hC0); setp(2, 1'b1, 2'd2, 32'hC2);
    #1 chk("mr_rdy", 64'(in_rdy), 64'h5);
    step;
    chk("mr_val", 64'(out_val), 64'h5);
    chk("mr_msg0", 64'(om(0)), 64'hC0);
    chk("mr_msg2", 64'(om(2)), 64'hC2);
    in_val = '0; reset = 1'b1;
    step;
    chk("mr_rst_val", 64'(out_val), 64'h0);
    chk("mr_rst_lo", out_msg[63:0], 64'h0);
    chk("mr_rst_hi", out_msg[127:64], 64'h0);
    reset = 1'b0;

    // fairness after reset (ptr[0] back to 0)
    out_rdy = 4'hf;
    setp(0, 1'b1, 2'd0, 32'hF0); setp(3, 1'b1, 2'd0, 32'hF3);
    for (int c = 0; c < 8; c++) begin
      #1 chk("fair_rdy", 64'(in_rdy), (c % 2) ? 64'h8 : 64'h1);
      if (in_rdy[0]) n0++;
      if (in_rdy[3]) n3++;
      step;
      chk("fair_msg", 64'(om(0)), (c % 2) ? 64'hF3 : 64'hF0);
    end
    chk("fair_n0", 64'(n0), 64'd4);
    chk("fair_n3", 64'(n3), 64'd4);
    in_val = '0;
    step;
    chk("fair_drain", 64'(out_val), 64'h0);
    chk("no_err4", 64'(err_drop), 64'h0);

    // bad destination on the 3-port instance alongside a legal transfer
    or3 = 3'b111;
    v3 = 3'b011;
    d3 = 6'b00_11_10;
    m3 = {32'h0, 32'hDEAD, 32'h55};
    #1 chk("bad_rdy", 64'(r3), 64'h3);
    step;
    chk("bad_err", 64'(e3), 64'h1);
    chk("bad_val", 64'(ov3), 64'h4);
    chk("bad_msg", 64'(om3[64 +: 32]), 64'h55);
    v3 = '0;
    step;
    chk("bad_err_pulse", 64'(e3), 64'h0);
    chk("bad_drain", 64'(ov3), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vc_arb_crossbar.md
VC_ARB_CROSSBAR -- requirements
Module: vc_arb_crossbar

Interface
REQ-001 SHALL have parameter NPORTS, default 4, giving the number of input ports and output ports (2..8).
REQ-002 SHALL have parameter BIT_WIDTH, default 32, giving the message width.
REQ-003 SHALL have parameter SEL_W, default 2, giving the destination field width; 2^SEL_W >= NPORTS.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_val, input, NPORTS bits: input i presents a message.
REQ-007 SHALL have port in_rdy, output, NPORTS bits: input i's message is accepted this cycle.
REQ-008 SHALL have port in_msg, input, NPORTS*BIT_WIDTH bits: input i at bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-009 SHALL have port in_dest, input, NPORTS*SEL_W bits: destination output of input i at [i*SEL_W +: SEL_W].
REQ-010 SHALL have port out_val, output, NPORTS bits: output j holds a valid message.
REQ-011 SHALL have port out_rdy, input, NPORTS bits: the sink of output j accepts this cycle.
REQ-012 SHALL have port out_msg, output, NPORTS*BIT_WIDTH bits, packed as in_msg.
REQ-013 SHALL have port err_drop, output, 1 bit: registered pulse, high one cycle after any bad-destination drop.

Function
REQ-014 SHALL transfer on input i when in_val[i] && in_rdy[i], and on output j when out_val[j] && out_rdy[j].
REQ-015 SHALL hold one-entry output register j (valid bit + message); out_val/out_msg are driven only from these registers.
REQ-016 SHALL treat output j as free when its register is empty or out_rdy[j]=1 (same-cycle drain and refill allowed).
REQ-017 SHALL have requesters of output j = inputs with in_val=1 and in_dest == j.
REQ-018 SHALL let free output j grant exactly one requester, chosen round-robin: first requester at or after ptr[j], searching upward mod NPORTS.
REQ-019 SHALL, on a grant to input i, set ptr[j] to (i+1) mod NPORTS next cycle; with no grant, ptr[j] is unchanged.
REQ-020 SHALL derive in_rdy[i] combinationally (1 when input i is granted) with no dependence of in_rdy on out_val of the same output beyond freeness.
REQ-021 SHALL load the granted message into register j at the edge of the transfer: latency exactly 1 cycle from input fire to out_val.
REQ-022 SHALL clear register j after an output fire with no new grant; keep it unchanged while out_val=1 and out_rdy=0.
REQ-023 SHALL let different outputs grant in the same cycle; up to NPORTS transfers per cycle.
REQ-024 SHALL, for in_dest >= NPORTS with in_val=1, assert in_rdy, discard the message and pulse err_drop next cycle.
REQ-025 SHALL not consume in_msg/in_dest/out_rdy bits when the corresponding valid is 0 (X-tolerant).
REQ-026 SHALL accept that a non-granted requester keeps in_val high; no message loss or duplication.

Reset
REQ-027 SHALL, while reset=1 at an edge, clear all out_val to 0, all out_msg to 0, all ptr to 0 and err_drop to 0.
REQ-028 SHALL force in_rdy to 0 while reset is high; in-flight register contents are discarded by reset mid-operation.

Verification (NPORTS=4, BIT_WIDTH=32)
REQ-029 SHALL pass identity routing: in_val=4'b1111, dest i->i, msg 0xA0+i, out_rdy=1 -> next cycle out_val=4'b1111, out_msg[j]=0xA0+j.
REQ-030 SHALL pass contention: inputs 0,1,2 all dest 3, held valid, out_rdy=1 -> out3 carries input 0, 1, 2 on consecutive cycles; ptr[3]=3 afterwards.
REQ-031 SHALL pass backpressure: out_rdy[1]=0 for 5 cycles with 2 messages for out1 -> first held stable, second stalled (in_rdy=0); release -> both delivered in order, no drops.
REQ-032 SHALL pass fairness: inputs 0 and 3 continuously to out0 for 8 cycles -> grants alternate 0,3,0,3..., 4 each.
REQ-033 SHALL pass bad-destination handling with NPORTS=3, SEL_W=2: dest=3 on input 1 -> in_rdy[1]=1, no out_val, err_drop=1 one cycle later.
REQ-034 SHALL pass reset mid-stream: reset asserted with out_val=4'b0101 -> next cycle out_val=0, out_msg=0, ptrs 0; traffic resumes normally after release.
